// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Common data bus arbiter. Each producer channel owns a small FIFO of
// {RoB index, value} results. A round-robin arbiter drains one entry per
// cycle onto a registered broadcast bus that RS, LSB and RoB all observe.
//
// Ports:
//   clk_in, rst_in    clock and asynchronous active-high reset
//   rdy_in            global ready; low freezes every register (no push, no pop)
//   flush_in          misprediction flush; empties all FIFOs, drops the broadcast
//   src_valid/index/data  per-channel push request, channel i in slice i
//   src_ready         per-channel "FIFO can accept" (count only, ignores same-cycle pop)
//   cdb_valid/index/data/src  registered broadcast and the channel it came from
//   cdb_pending       at least one FIFO holds an entry
//   overflow_err      sticky flag: a push was attempted into a full FIFO
module cdb_arbiter #(
  parameter int RoB_WIDTH  = 3,
  parameter int NUM_SRC    = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*RoB_WIDTH-1:0] src_index,
  input  logic [NUM_SRC*32-1:0]        src_data,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic                         cdb_valid,
  output logic [RoB_WIDTH-1:0]         cdb_index,
  output logic [31:0]                  cdb_data,
  output logic [SRC_W-1:0]             cdb_src,
  output logic                         cdb_pending,
  output logic                         overflow_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [SRC_W:0]   NUM_SRC_W = (SRC_W + 1)'(NUM_SRC);

  logic [RoB_WIDTH-1:0] mem_index [NUM_SRC][FIFO_DEPTH];
  logic [31:0]          mem_data  [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr    [NUM_SRC];
  logic [PTR_W-1:0]     wr_ptr    [NUM_SRC];
  logic [CNT_W-1:0]     count     [NUM_SRC];
  logic [SRC_W-1:0]     rr_ptr;

  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] push_en;
  logic [NUM_SRC-1:0] pop_en;
  logic [NUM_SRC-1:0] rotated;
  logic [SRC_W:0]     offset;
  logic [SRC_W:0]     grant_sum;
  logic [SRC_W:0]     next_rr_sum;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   next_rr;
  logic               grant_valid;
  logic               advance;
  logic               overflow_now;

  // FIFO status. Readiness looks only at the current count, so a full FIFO
  // refuses a push even in a cycle where it is also being popped.
  always_comb begin
    nonempty  = '0;
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      nonempty[i]  = (count[i] != '0);
      src_ready[i] = rdy_in && (count[i] != FULL_CNT);
    end
  end

  assign cdb_pending  = |nonempty;
  assign advance      = rdy_in && !flush_in;
  assign overflow_now = rdy_in && (|(src_valid & ~src_ready));

  // Round-robin grant: rotate the non-empty mask so rr_ptr lands on bit 0,
  // pick the lowest set bit, then rotate the offset back to a channel id.
  always_comb begin
    rotated = NUM_SRC'({nonempty, nonempty} >> rr_ptr);
    offset  = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rotated[k]) offset = (SRC_W + 1)'(k);
    end
    grant_valid = |rotated;
    grant_sum   = {1'b0, rr_ptr} + offset;
    if (grant_sum >= NUM_SRC_W) grant_sum = grant_sum - NUM_SRC_W;
    grant       = grant_sum[SRC_W-1:0];
    next_rr_sum = {1'b0, grant} + (SRC_W + 1)'(1);
    if (next_rr_sum == NUM_SRC_W) next_rr_sum = '0;
    next_rr     = next_rr_sum[SRC_W-1:0];
  end

  // Per-channel push and pop strobes for this edge.
  always_comb begin
    push_en = '0;
    pop_en  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      push_en[i] = advance && src_valid[i] && src_ready[i];
      pop_en[i]  = advance && grant_valid && (grant == SRC_W'(i));
    end
  end

  // FIFO pointers, counts and the round-robin pointer. Flush wins over
  // everything except reset and does not depend on rdy_in.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
    end else if (flush_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push_en[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop_en[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        if (push_en[i] && !pop_en[i])      count[i] <= count[i] + CNT_W'(1);
        else if (!push_en[i] && pop_en[i]) count[i] <= count[i] - CNT_W'(1);
      end
      if (grant_valid) rr_ptr <= next_rr;
    end
  end

  // FIFO storage; contents need no reset because the counts gate visibility.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push_en[i]) begin
        mem_index[i][wr_ptr[i]] <= src_index[i*RoB_WIDTH +: RoB_WIDTH];
        mem_data[i][wr_ptr[i]]  <= src_data[i*32 +: 32];
      end
    end
  end

  // Registered broadcast. A stall holds the whole bus; a flush only drops
  // the valid bit. The overflow flag is sticky until reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cdb_valid    <= 1'b0;
      cdb_index    <= '0;
      cdb_data     <= '0;
      cdb_src      <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (overflow_now) overflow_err <= 1'b1;
      if (flush_in) begin
        cdb_valid <= 1'b0;
      end else if (rdy_in) begin
        if (grant_valid) begin
          cdb_valid <= 1'b1;
          cdb_index <= mem_index[grant][rd_ptr[grant]];
          cdb_data  <= mem_data[grant][rd_ptr[grant]];
          cdb_src   <= grant;
        end else begin
          cdb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter (RoB_WIDTH=3, NUM_SRC=2, FIFO_DEPTH=4).
// A queue-based reference model tracks accepted pushes per channel and the
// expected broadcast; every clock it is compared against the DUT. A vector
// table covers the single-entry and interleaved broadcast sequences, and
// hand-written sequences cover reset, overflow, flush and stall.
module tb_cdb_arbiter;

  localparam int FD = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic [1:0]  src_valid;
  logic [5:0]  src_index;
  logic [63:0] src_data;
  logic [1:0]  src_ready;
  logic        cdb_valid;
  logic [2:0]  cdb_index;
  logic [31:0] cdb_data;
  logic        cdb_src;
  logic        cdb_pending;
  logic        overflow_err;

  cdb_arbiter #(.RoB_WIDTH(3), .NUM_SRC(2), .FIFO_DEPTH(FD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .src_valid(src_valid), .src_index(src_index), .src_data(src_data),
    .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_index(cdb_index),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .cdb_pending(cdb_pending),
    .overflow_err(overflow_err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
  } entry_t;

  typedef struct {
    logic [1:0]  valid;
    logic [2:0]  idx0, idx1;
    logic [31:0] d0, d1;
    logic        e_valid;
    logic        e_src;
    logic [2:0]  e_idx;
    logic [31:0] e_data;
  } vec_t;

  entry_t q0[$];
  entry_t q1[$];
  logic        m_rr, m_valid, m_src, m_ovf;
  logic [2:0]  m_idx;
  logic [31:0] m_data;
  int checks = 0;
  int errors = 0;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    m_rr = 0; m_valid = 0; m_src = 0; m_ovf = 0; m_idx = 0; m_data = 0;
  endtask

  // Advance the reference model by one edge using the inputs now driven.
  task automatic modelStep();
    int s0 = q0.size();
    int s1 = q1.size();
    logic found = 0;
    logic g = 0;
    entry_t e;
    if (rdy_in && ((src_valid[0] && s0 == FD) || (src_valid[1] && s1 == FD))) m_ovf = 1;
    if (flush_in) begin
      q0.delete();
      q1.delete();
      m_rr = 0;
      m_valid = 0;
      return;
    end
    if (!rdy_in) return;
    if (m_rr == 0) begin
      if (s0 > 0) begin found = 1; g = 0; end
      else if (s1 > 0) begin found = 1; g = 1; end
    end else begin
      if (s1 > 0) begin found = 1; g = 1; end
      else if (s0 > 0) begin found = 1; g = 0; end
    end
    if (found) begin
      if (g) e = q1.pop_front();
      else   e = q0.pop_front();
      m_valid = 1; m_idx = e.idx; m_data = e.data; m_src = g; m_rr = ~g;
    end else begin
      m_valid = 0;
    end
    if (src_valid[0] && s0 < FD) q0.push_back('{src_index[2:0], src_data[31:0]});
    if (src_valid[1] && s1 < FD) q1.push_back('{src_index[5:3], src_data[63:32]});
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic [1:0] v,
                               input logic [2:0] i0, input logic [2:0] i1,
                               input logic [31:0] d0, input logic [31:0] d1);
    rdy_in    = r;
    flush_in  = f;
    src_valid = v;
    src_index = {i1, i0};
    src_data  = {d1, d0};
  endtask

  task automatic checkOutput();
    logic [1:0] exp_ready;
    exp_ready = {rdy_in && (q1.size() != FD), rdy_in && (q0.size() != FD)};
    check("cdb_valid", cdb_valid, m_valid);
    check("cdb_index", cdb_index, m_idx);
    check("cdb_data", cdb_data, m_data);
    check("cdb_src", cdb_src, m_src);
    check("src_ready", src_ready, exp_ready);
    check("cdb_pending", cdb_pending, (q0.size() != 0) || (q1.size() != 0));
    check("overflow_err", overflow_err, m_ovf);
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk_in);
    #1;
    checkOutput();
  endtask

  function automatic vec_t mk(input logic [1:0] v, input logic [2:0] i0, input logic [2:0] i1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic ev, input logic es, input logic [2:0] ei,
                              input logic [31:0] ed);
    vec_t r;
    r.valid = v; r.idx0 = i0; r.idx1 = i1; r.d0 = d0; r.d1 = d1;
    r.e_valid = ev; r.e_src = es; r.e_idx = ei; r.e_data = ed;
    return r;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Single ch1 entry, then three interleaved pairs drained 0,1,0,1,0,1.
    vecs[0]  = mk(2'b10, 3'd0, 3'd5, 32'h0,         32'hDEADBEEF, 0, 0, 3'd0, 32'h0);
    vecs[1]  = mk(2'b00, 3'd0, 3'd0, 32'h0,         32'h0,        1, 1, 3'd5, 32'hDEADBEEF);
    vecs[2]  = mk(2'b00, 3'd0, 3'd0, 32'h0,         32'h0,        0, 1, 3'd5, 32'hDEADBEEF);
    vecs[3]  = mk(2'b11, 3'd1, 3'd4, 32'hA0000001, 32'hB0000004,  0, 1, 3'd5, 32'hDEADBEEF);
    vecs[4]  = mk(2'b11, 3'd2, 3'd5, 32'hA0000002, 32'hB0000005,  1, 0, 3'd1, 32'hA0000001);
    vecs[5]  = mk(2'b11, 3'd3, 3'd6, 32'hA0000003, 32'hB0000006,  1, 1, 3'd4, 32'hB0000004);
    vecs[6]  = mk(2'b00, 3'd0, 3'd0, 32'h0,         32'h0,        1, 0, 3'd2, 32'hA0000002);
    vecs[7]  = mk(2'b00, 3'd0, 3'd0, 32'h0,         32'h0,        1, 1, 3'd5, 32'hB0000005);
    vecs[8]  = mk(2'b00, 3'd0, 3'd0, 32'h0,         32'h0,        1, 0, 3'd3, 32'hA0000003);
    vecs[9]  = mk(2'b00, 3'd0, 3'd0, 32'h0,         32'h0,        1, 1, 3'd6, 32'hB0000006);
    vecs[10] = mk(2'b00, 3'd0, 3'd0, 32'h0,         32'h0,        0, 1, 3'd6, 32'hB0000006);

    rst_in = 1;
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0);
    modelReset();
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput();
    rst_in = 0;

    // Build up traffic, then reset asynchronously mid-cycle.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 0, 2'b11, 3'(c), 3'(c + 4), 32'h10 + c, 32'h20 + c);
      tick();
    end
    check("pre_reset_valid", cdb_valid, 1);
    check("pre_reset_pending", cdb_pending, 1);
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0);
    #3 rst_in = 1;
    modelReset();
    #1;
    checkOutput();
    check("reset_src_ready", src_ready, 2'b11);
    #1 rst_in = 0;

    $display("[TB] vector table");
    for (int n = 0; n < 11; n++) begin
      applyStimulus(1, 0, vecs[n].valid, vecs[n].idx0, vecs[n].idx1, vecs[n].d0, vecs[n].d1);
      tick();
      check($sformatf("vec%0d_valid", n), cdb_valid, vecs[n].e_valid);
      check($sformatf("vec%0d_src", n), cdb_src, vecs[n].e_src);
      check($sformatf("vec%0d_index", n), cdb_index, vecs[n].e_idx);
      check($sformatf("vec%0d_data", n), cdb_data, vecs[n].e_data);
    end

    $display("[TB] overflow");
    for (int c = 0; c < 40 && q0.size() < FD; c++) begin
      applyStimulus(1, 0, {c % 2 == 0, 1'b1}, 3'(c), 3'(c + 1), 32'hC0000000 + c, 32'hD0000000 + c);
      tick();
    end
    check("full_not_ready", src_ready[0], 0);
    check("no_overflow_yet", overflow_err, 0);
    applyStimulus(1, 0, 2'b01, 3'd7, 3'd0, 32'hBAD00005, 32'h0);
    tick();
    check("overflow_set", overflow_err, 1);
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0);
    for (int c = 0; c < 20 && (q0.size() != 0 || q1.size() != 0); c++) tick();
    check("drained", cdb_pending, 0);

    $display("[TB] flush");
    applyStimulus(1, 0, 2'b11, 3'd1, 3'd2, 32'hE1E1E1E1, 32'hE2E2E2E2);
    tick();
    check("flush_pre_pending", cdb_pending, 1);
    applyStimulus(1, 1, 2'b01, 3'd3, 3'd0, 32'hF1F1F1F1, 32'h0);
    tick();
    check("flush_valid", cdb_valid, 0);
    check("flush_pending", cdb_pending, 0);
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0);
    tick();
    check("flush_no_bcast", cdb_valid, 0);
    check("overflow_survives_flush", overflow_err, 1);

    $display("[TB] stall");
    applyStimulus(1, 0, 2'b11, 3'd2, 3'd6, 32'h22222222, 32'h66666666);
    tick();
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0);
    tick();
    check("stall_pre_valid", cdb_valid, 1);
    check("stall_pre_index", cdb_index, 3'd2);
    applyStimulus(0, 0, 2'b11, 3'd4, 3'd4, 32'h44444444, 32'h44444444);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_valid", cdb_valid, 1);
      check("stall_index", cdb_index, 3'd2);
      check("stall_ready", src_ready, 2'b00);
    end
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0);
    tick();
    check("resume_valid", cdb_valid, 1);
    check("resume_index", cdb_index, 3'd6);
    check("resume_src", cdb_src, 1);
    tick();
    check("resume_idle", cdb_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
